// File: rtl/io_out_fifo.sv
// io_out_fifo: first-word-fall-through buffer behind the core's output port, drained over valid/ready.
// Optional macro IO_OUT_SHADOW_EN adds a per-address shadow of the last data written by the core.
module io_out_fifo #(
  parameter int NUBITS = 32,
  parameter int NUIOOU = 8,
  parameter int FDEPTH = 8,
  localparam int AW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1,
  localparam int PW = $clog2(FDEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              out_en,
  input  logic [AW-1:0]     addr_out,
  input  logic [NUBITS-1:0] data_in,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [AW-1:0]     m_addr,
  output logic [NUBITS-1:0] m_data,
  output logic [PW:0]       count,
  output logic              full,
  output logic              empty,
  output logic              ovf,
`ifdef IO_OUT_SHADOW_EN
  output logic [NUIOOU*NUBITS-1:0] shadow,
`endif
  input  logic              ovf_clr
);

  localparam logic [PW:0] DEPTH = (PW+1)'(FDEPTH);

  logic [AW-1:0]     mem_addr [FDEPTH];
  logic [NUBITS-1:0] mem_data [FDEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [PW:0]       count_q;
  logic              ovf_q;
  logic              push;
  logic              pop;

  assign full    = (count_q == DEPTH);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign ovf     = ovf_q;
  assign m_valid = ~empty;
  assign m_addr  = empty ? '0 : mem_addr[rptr];
  assign m_data  = empty ? '0 : mem_data[rptr];

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a write.
  assign pop  = m_valid & m_ready;
  assign push = out_en & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wptr] <= addr_out;
      mem_data[wptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      if (push && !pop)
        count_q <= count_q + (PW+1)'(1);
      else if (pop && !push)
        count_q <= count_q - (PW+1)'(1);
      // A fresh overflow outranks a clear request in the same cycle.
      if (out_en && full && !pop)
        ovf_q <= 1'b1;
      else if (ovf_clr)
        ovf_q <= 1'b0;
    end
  end

`ifdef IO_OUT_SHADOW_EN
  // Shadow tracks every core write, including ones the FIFO dropped.
  for (genvar a = 0; a < NUIOOU; a++) begin : g_shadow
    logic [NUBITS-1:0] slice_q;
    always_ff @(posedge clk) begin
      if (rst)
        slice_q <= '0;
      else if (out_en && addr_out == AW'(a))
        slice_q <= data_in;
    end
    assign shadow[a*NUBITS +: NUBITS] = slice_q;
  end
`endif

endmodule

// File: tb/tb_io_out_fifo.sv
// tb_io_out_fifo: table vectors, directed corner sequences and random traffic against a queue model.
// Shadow checks are compiled in when IO_OUT_SHADOW_EN is defined.
module tb_io_out_fifo;

  localparam int NUBITS = 32;
  localparam int NUIOOU = 8;
  localparam int FDEPTH = 8;
  localparam int AW = 3;
  localparam int PW = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              out_en = 1'b0;
  logic [AW-1:0]     addr_out = '0;
  logic [NUBITS-1:0] data_in = '0;
  logic              m_ready = 1'b0;
  logic              ovf_clr = 1'b0;
  logic              m_valid;
  logic [AW-1:0]     m_addr;
  logic [NUBITS-1:0] m_data;
  logic [PW:0]       count;
  logic              full;
  logic              empty;
  logic              ovf;
`ifdef IO_OUT_SHADOW_EN
  logic [NUIOOU*NUBITS-1:0] shadow;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  io_out_fifo #(.NUBITS(NUBITS), .NUIOOU(NUIOOU), .FDEPTH(FDEPTH)) dut (
    .clk(clk), .rst(rst), .out_en(out_en), .addr_out(addr_out), .data_in(data_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
    .count(count), .full(full), .empty(empty), .ovf(ovf),
`ifdef IO_OUT_SHADOW_EN
    .shadow(shadow),
`endif
    .ovf_clr(ovf_clr)
  );

  // Reference model: an ordered queue of entries plus a sticky flag and per-address shadow.
  typedef struct {
    logic [AW-1:0]     a;
    logic [NUBITS-1:0] d;
  } ent_t;

  ent_t              mq[$];
  bit                m_ovf;
  logic [NUBITS-1:0] m_sh [NUIOOU];

  typedef struct {
    logic              r, e;
    logic [AW-1:0]     a;
    logic [NUBITS-1:0] d;
    logic              rdy, clr;
    logic [PW:0]       cnt;
    logic              vld;
    logic [AW-1:0]     ea;
    logic [NUBITS-1:0] ed;
    logic              eovf;
  } vec_t;

  vec_t vecs[$];

  task automatic compare(input string name, input logic [NUBITS-1:0] act, input logic [NUBITS-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    int n;
    n = mq.size();
    compare({tag, " m_valid"}, NUBITS'(m_valid), NUBITS'(n != 0));
    compare({tag, " m_addr"}, NUBITS'(m_addr), (n != 0) ? NUBITS'(mq[0].a) : '0);
    compare({tag, " m_data"}, m_data, (n != 0) ? mq[0].d : '0);
    compare({tag, " count"}, NUBITS'(count), NUBITS'(n));
    compare({tag, " full"}, NUBITS'(full), NUBITS'(n == FDEPTH));
    compare({tag, " empty"}, NUBITS'(empty), NUBITS'(n == 0));
    compare({tag, " ovf"}, NUBITS'(ovf), NUBITS'(m_ovf));
`ifdef IO_OUT_SHADOW_EN
    for (int k = 0; k < NUIOOU; k++)
      compare($sformatf("%s shadow%0d", tag, k), shadow[k*NUBITS +: NUBITS], m_sh[k]);
`endif
  endtask

  // Drive one cycle of inputs, advance the model by the same edge, then check at the falling edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [AW-1:0] a,
                               input logic [NUBITS-1:0] d, input logic rd, input logic c,
                               input string tag);
    bit do_pop, do_push;
    rst = r; out_en = e; addr_out = a; data_in = d; m_ready = rd; ovf_clr = c;
    if (r) begin
      mq.delete();
      m_ovf = 0;
      for (int k = 0; k < NUIOOU; k++) m_sh[k] = '0;
    end else begin
      do_pop  = (mq.size() != 0) && rd;
      do_push = e && ((mq.size() < FDEPTH) || do_pop);
      if (e) m_sh[a] = d;
      if (e && mq.size() == FDEPTH && !do_pop) m_ovf = 1;
      else if (c) m_ovf = 0;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{a: a, d: d});
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic add_vec(input logic r, e, input logic [AW-1:0] a, input logic [NUBITS-1:0] d,
                         input logic rdy, clr, input logic [PW:0] cnt, input logic vld,
                         input logic [AW-1:0] ea, input logic [NUBITS-1:0] ed, input logic eovf);
    vecs.push_back('{r: r, e: e, a: a, d: d, rdy: rdy, clr: clr, cnt: cnt, vld: vld,
                     ea: ea, ed: ed, eovf: eovf});
  endtask

  initial begin
    // Reset, idle, single write held, pop, ready-while-empty, push-while-empty, push+pop of one entry.
    add_vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 1, 3, 32'hAB, 0, 0, 1, 1, 3, 32'hAB, 0);
    for (int i = 0; i < 5; i++) add_vec(0, 0, 0, 0, 0, 0, 1, 1, 3, 32'hAB, 0);
    add_vec(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add_vec(0, 1, 5, 32'h1234, 1, 0, 1, 1, 5, 32'h1234, 0);
    add_vec(0, 1, 6, 32'h77, 1, 0, 1, 1, 6, 32'h77, 0);
    add_vec(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].r, vecs[i].e, vecs[i].a, vecs[i].d, vecs[i].rdy, vecs[i].clr,
                    $sformatf("vec%0d", i));
      compare($sformatf("vec%0d tbl count", i), NUBITS'(count), NUBITS'(vecs[i].cnt));
      compare($sformatf("vec%0d tbl valid", i), NUBITS'(m_valid), NUBITS'(vecs[i].vld));
      compare($sformatf("vec%0d tbl addr", i), NUBITS'(m_addr), NUBITS'(vecs[i].ea));
      compare($sformatf("vec%0d tbl data", i), m_data, vecs[i].ed);
      compare($sformatf("vec%0d tbl ovf", i), NUBITS'(ovf), NUBITS'(vecs[i].eovf));
    end

    // Fill to full, overflow with data 9, drain in order.
    for (int i = 1; i <= FDEPTH; i++) applyStimulus(0, 1, AW'(i - 1), i, 0, 0, "fill");
    compare("fill full", NUBITS'(full), 1);
    compare("fill count", NUBITS'(count), FDEPTH);
    applyStimulus(0, 1, 7, 9, 0, 0, "overflow");
    compare("overflow ovf", NUBITS'(ovf), 1);
    compare("overflow count", NUBITS'(count), FDEPTH);
    for (int i = 1; i <= FDEPTH; i++) begin
      compare($sformatf("drain order %0d", i), m_data, i);
      applyStimulus(0, 0, 0, 0, 1, 0, "drain");
    end
    compare("drained empty", NUBITS'(empty), 1);
    applyStimulus(0, 0, 0, 0, 0, 1, "clear");
    compare("clear ovf", NUBITS'(ovf), 0);

    // Full with simultaneous push and pop.
    for (int i = 1; i <= FDEPTH; i++) applyStimulus(0, 1, AW'(i), i, 0, 0, "refill");
    applyStimulus(0, 1, 2, 32'h55, 1, 0, "full push+pop");
    compare("pushpop count", NUBITS'(count), FDEPTH);
    compare("pushpop ovf", NUBITS'(ovf), 0);
    for (int i = 2; i <= FDEPTH; i++) begin
      compare($sformatf("pushpop order %0d", i), m_data, i);
      applyStimulus(0, 0, 0, 0, 1, 0, "drain2");
    end
    compare("pushpop last", m_data, 32'h55);
    applyStimulus(0, 0, 0, 0, 1, 0, "drain2");
    compare("pushpop empty", NUBITS'(empty), 1);

    // Clear and overflow in the same cycle: set wins.
    for (int i = 1; i <= FDEPTH; i++) applyStimulus(0, 1, AW'(i), 32'h100 + i, 0, 0, "fill3");
    applyStimulus(0, 1, 0, 32'h99, 0, 1, "clr+ovf");
    compare("clr+ovf ovf", NUBITS'(ovf), 1);
    applyStimulus(0, 0, 0, 0, 0, 1, "clr alone");
    compare("clr alone ovf", NUBITS'(ovf), 0);

    // Reset in the middle of a drain.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0, "part drain");
    compare("part drain count", NUBITS'(count), 5);
    applyStimulus(1, 1, 4, 32'hDEAD, 1, 0, "mid rst");
    compare("mid rst count", NUBITS'(count), 0);
    compare("mid rst valid", NUBITS'(m_valid), 0);
    applyStimulus(0, 1, 1, 7, 0, 0, "post rst write");
    compare("post rst count", NUBITS'(count), 1);
    compare("post rst addr", NUBITS'(m_addr), 1);
    compare("post rst data", m_data, 7);
`ifdef IO_OUT_SHADOW_EN
    compare("post rst shadow1", shadow[1*NUBITS +: NUBITS], 7);
    compare("post rst shadow4", shadow[4*NUBITS +: NUBITS], 0);
`endif
    applyStimulus(0, 0, 0, 0, 1, 0, "post rst pop");

    // Random traffic: a filling phase then a draining-biased phase.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 99) < 60,
                    AW'($urandom_range(0, NUIOOU - 1)),
                    $urandom,
                    $urandom_range(0, 99) < ((i < 300) ? 30 : 70),
                    $urandom_range(0, 99) < 5,
                    "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_out_fifo.md
Name: io_out_fifo

Overview:
- Output-side buffer placed directly downstream of the fixed-point core's output interface.
- Captures every output-port write (out_en, addr_out, data_out) into a small first-word-fall-through FIFO.
- Drains entries to a slower peripheral side through a valid/ready handshake, so the core never stalls.
- Reports fill level and a sticky overflow flag for firmware/debug.

Parameters:
- NUBITS, 32, data word width (matches core data_out).
- NUIOOU, 8, number of output port addresses; address width AW = $clog2(NUIOOU).
- FDEPTH, 8, FIFO depth in entries; power of two, >= 2; pointer width PW = $clog2(FDEPTH).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- out_en  input  1  core output strobe, one write per asserted cycle.
- addr_out  input  AW  core output port address, sampled with out_en.
- data_in  input  NUBITS  core data_out, sampled with out_en.
- m_valid  output  1  head entry available.
- m_ready  input  1  consumer accepts head entry when m_valid is high.
- m_addr  output  AW  head entry address; 0 when empty.
- m_data  output  NUBITS  head entry data; 0 when empty.
- count  output  PW+1  number of stored entries, 0..FDEPTH.
- full  output  1  count == FDEPTH.
- empty  output  1  count == 0.
- ovf  output  1  sticky overflow flag.
- ovf_clr  input  1  clears ovf.

Behaviour:
- Reset: sync on rst=1 at a clock edge. Clears wptr, rptr, count and ovf. After reset: m_valid=0, empty=1, full=0, m_addr=0, m_data=0. Storage array is not reset. rst has priority over every other input, including mid-drain.
- Storage: FDEPTH entries of {addr, data}, implemented as register array. Pointers are PW bits and wrap modulo FDEPTH. count is held as a separate register.
- Push: occurs when out_en=1 and (full=0 or pop this cycle). Writes {addr_out, data_in} at wptr; wptr increments.
- Pop: occurs when m_valid=1 and m_ready=1; rptr increments.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop when full: both happen, count stays FDEPTH.
- Simultaneous push and pop when empty: no pop (m_valid=0); push happens, count becomes 1.
- Latency: entry pushed at edge N appears on m_addr/m_data with m_valid=1 after edge N. There is no fall-through within the same cycle.
- Head outputs: m_valid = ~empty. m_addr/m_data are combinational from mem[rptr], gated to 0 when empty. They stay stable while m_valid=1 and m_ready=0.
- Overflow: out_en=1 while full=1 and no pop means the write is dropped. ovf is set at the next edge, and FIFO contents are unchanged.
- ovf clearing: ovf stays set until an edge with ovf_clr=1. If ovf_clr and a new overflow occur in the same cycle, set wins.
- m_ready while empty: ignored.
- Ordering: strict FIFO order, no reordering by address.

Optional Feature:
- Macro: IO_OUT_SHADOW_EN.
- Defined:
  - Adds output shadow, width NUIOOU*NUBITS. Slice [a*NUBITS +: NUBITS] holds the last data written by the core to address a.
  - A shadow slice updates at the edge of every out_en, including writes dropped on overflow.
  - All slices reset to 0.
  - Addresses >= NUIOOU (non-power-of-two NUIOOU) are ignored.
- Not defined: port shadow absent; no shadow registers synthesized.

Test Plan:
- Reset, then idle 3 cycles -> m_valid=0, empty=1, count=0, m_addr=0, m_data=0, ovf=0.
- Single write: out_en with addr=3, data=0x0000_00AB at edge N, m_ready=0 -> from N+1: m_valid=1, m_addr=3, m_data=0xAB, count=1, held 5 cycles. Then m_ready=1 for one cycle -> empty=1 next cycle.
- Fill with data 1..8 (FDEPTH=8), m_ready=0 -> full=1, count=8. Ninth write, data 9 -> ovf=1 next cycle, count=8. Drain with m_ready=1 -> values read out 1..8 in order; 9 never appears.
- Full plus simultaneous push (data 0x55) and pop -> count stays 8, ovf stays 0. 0x55 emerges as the last entry after draining.
- ovf_clr and overflow in the same cycle -> ovf remains 1. ovf_clr alone next cycle -> ovf=0.
- Assert rst mid-drain with count=5 -> next cycle count=0, m_valid=0. A subsequent write of addr=1, data=7 -> appears alone. With IO_OUT_SHADOW_EN: shadow slice 1 = 7, other slices 0.
